avalon_mm_master: RTL
=====================

// Module: avalon_mm_master
// PURPOSE
//  Avalon-MM initiator: turns single read/write commands from the register-verification
//  sequencer into Avalon-MM transfers to avalon_mm_slave, honouring waitrequest.
//  Returns one response (read data / error) per command. One transfer in flight at a time.
//  A waitrequest timeout keeps the bench from hanging on a stuck slave.
// PARAMETERS
//  DW       32      data width (bits)
//  N        DW/8    byte lanes (width of byteenable)
//  AW       32      address width; word address, passed to the slave unchanged
//  TIMEOUT  64      max bus cycles per transfer before abort; 0 = no timeout
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  reset        in   1   asynchronous, active-low reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   master can accept a command this cycle
//  cmd_write    in   1   1 = write, 0 = read
//  cmd_addr     in   AW  target address
//  cmd_wdata    in   DW  write data (ignored for reads)
//  cmd_byteen   in   N   byte enables
//  rsp_valid    out  1   one-cycle pulse: transfer finished
//  rsp_rdata    out  DW  read data; 0 for writes and aborts
//  rsp_error    out  1   1 = aborted on timeout (valid with rsp_valid)
//  address      out  AW  Avalon address
//  chipselect   out  1   Avalon chipselect
//  read         out  1   Avalon read
//  write        out  1   Avalon write
//  writedata    out  DW  Avalon write data
//  byteenable   out  N   Avalon byte enables
//  readdata     in   DW  Avalon read data, valid when read=1 and waitrequest=0
//  waitrequest  in   1   Avalon stall
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, all outputs 0 (incl. cmd_ready), wait counter 0.
//  All outputs registered. States: IDLE, ACCESS.
//  IDLE: cmd_ready=1; bus outputs all 0. cmd_valid&cmd_ready at edge E0 -> capture
//   cmd_*, go ACCESS; from E0: chipselect=1, read=~cmd_write, write=cmd_write,
//   address/writedata/byteenable = captured values; cmd_ready=0.
//  ACCESS: bus outputs held constant every cycle. At each edge:
//   - waitrequest=0: transfer done. Read: rsp_rdata<=readdata. Write: rsp_rdata<=0.
//     rsp_valid<=1, rsp_error<=0, bus outputs<=0, go IDLE.
//   - waitrequest=1, TIMEOUT!=0, counter==TIMEOUT-1: abort; rsp_valid<=1,
//     rsp_error<=1, rsp_rdata<=0, bus outputs<=0, go IDLE.
//   - else counter+1, stay. Counter cleared on entry to ACCESS; width clog2(TIMEOUT+1).
//  Latency: zero-wait transfer -> bus active 1 cycle, rsp_valid in cycle after E0+1;
//   W wait cycles -> bus active W+1 cycles, rsp_valid 1 cycle later.
//  rsp_valid high exactly one cycle; rsp_rdata/rsp_error hold until next response.
//  Back-to-back: cmd_ready=1 in same cycle as rsp_valid; next command accepted then,
//   so exactly one idle bus cycle between consecutive transfers.
//  cmd_* ignored when cmd_ready=0; no queuing. Never read=write=1.
//  Reset mid-transfer: bus dropped immediately, no rsp_valid; after reset release
//   first edge -> IDLE with cmd_ready=1.
// TESTING
//  1 write addr 0x10 data 0xDEADBEEF be 4'hF, waitrequest=0 -> write=1 one cycle,
//    slave Mem[0x10]=0xDEADBEEF, rsp_valid 1 cycle, rsp_error=0, rsp_rdata=0.
//  2 read addr 0x5, waitrequest=1 for 3 cycles -> read/address=0x5 stable 4 cycles,
//    rsp_rdata=0x00000005 (slave init Mem[i]=i), rsp_error=0.
//  3 TIMEOUT=8, waitrequest stuck 1 on read -> bus held exactly 8 cycles, then
//    rsp_valid, rsp_error=1, rsp_rdata=0, cmd_ready=1.
//  4 cmd_valid held, write 0x20<-0xA5A5A5A5 then read 0x20 -> second accepted in
//    rsp_valid cycle, one idle bus cycle between, read returns 0xA5A5A5A5.
//  5 reset=0 during ACCESS wait -> chipselect/read/write 0 same cycle, no rsp_valid;
//    after release cmd_ready=1 and a new read 0x3 returns 0x00000003.
//  6 write be 4'b0011 -> byteenable=4'b0011 on bus for full transfer duration.

Source files
------------

// File: rtl/avalon_mm_master_if.sv
// Command, response and Avalon-MM bus signals between the sequencer, the master and the slave.
// The master modport is the initiator's view; the slave modport is the sequencer + slave side.
interface avalon_mm_master_if #(
    parameter int DW = 32,
    parameter int N  = DW / 8,
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [N-1:0]  cmd_byteen;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [N-1:0]  byteenable;
    logic [DW-1:0] readdata;
    logic          waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_byteen, readdata, waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output address, chipselect, read, write, writedata, byteenable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_byteen, readdata, waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  address, chipselect, read, write, writedata, byteenable
    );
endinterface

// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: one command in flight, waitrequest-aware, with a bus-cycle timeout
// that aborts a stuck transfer and reports it through rsp_error.
//
// state    | meaning
// S_IDLE   | bus quiet, cmd_ready=1 (except first cycle after reset)
// S_ACCESS | transfer on the bus, waiting for waitrequest=0 or timeout
module avalon_mm_master #(
    parameter int DW      = 32,
    parameter int N       = DW / 8,
    parameter int AW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    avalon_mm_master_if.master  bus
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_cmd_ready, w_cmd_ready;
    logic          r_cs, w_cs;
    logic          r_rd, w_rd;
    logic          r_wr, w_wr;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_wdata, w_wdata;
    logic [N-1:0]  r_be, w_be;
    logic          r_rsp_valid, w_rsp_valid;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata;
    logic          r_rsp_error, w_rsp_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_cs        <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cmd_ready <= w_cmd_ready;
            r_cs        <= w_cs;
            r_rd        <= w_rd;
            r_wr        <= w_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_be        <= w_be;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_error <= w_rsp_error;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cmd_ready = 1'b0;
        w_cs        = r_cs;
        w_rd        = r_rd;
        w_wr        = r_wr;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_be        = r_be;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_error = r_rsp_error;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state = S_ACCESS;
                    w_cnt   = '0;
                    w_cs    = 1'b1;
                    w_rd    = ~bus.cmd_write;
                    w_wr    = bus.cmd_write;
                    w_addr  = bus.cmd_addr;
                    w_wdata = bus.cmd_wdata;
                    w_be    = bus.cmd_byteen;
                end else begin
                    w_cmd_ready = 1'b1;
                    w_cs        = 1'b0;
                    w_rd        = 1'b0;
                    w_wr        = 1'b0;
                    w_addr      = '0;
                    w_wdata     = '0;
                    w_be        = '0;
                end
            end
            S_ACCESS: begin
                // Completion and abort both drop the bus and re-open cmd_ready together
                // with rsp_valid, giving exactly one idle bus cycle between transfers.
                if (!bus.waitrequest || ((TIMEOUT != 0) && (r_cnt == CNT_LAST))) begin
                    w_state     = S_IDLE;
                    w_cmd_ready = 1'b1;
                    w_cs        = 1'b0;
                    w_rd        = 1'b0;
                    w_wr        = 1'b0;
                    w_addr      = '0;
                    w_wdata     = '0;
                    w_be        = '0;
                    w_rsp_valid = 1'b1;
                    w_rsp_error = bus.waitrequest;
                    w_rsp_rdata = (!bus.waitrequest && r_rd) ? bus.readdata : '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.chipselect = r_cs;
    assign bus.read       = r_rd;
    assign bus.write      = r_wr;
    assign bus.address    = r_addr;
    assign bus.writedata  = r_wdata;
    assign bus.byteenable = r_be;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_error  = r_rsp_error;
endmodule
